display_scan_scheduler: RTL and testbench

- Sequences the 4-digit multiplexed 7-segment display: times each digit slot, inserts anti-ghosting blanking, and drives the digit enables and the BCD value for the shared BCD-to-7-segment decoder.
- Arbitrates between two requesters: live value A, and overlay B (messages or errors) via a req/ack handshake.
- Latches the displayed word once per frame, so values never tear mid-scan. Sits between the counter/FSM logic and the decoder.

---
 rtl/display_scan_scheduler.sv | 147 ++++++++++++++
 tb/tb_display_scan_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler.sv
// rtl/display_scan_scheduler.sv - 4-digit 7-segment scan sequencer with overlay arbitration
// All outputs are registered; they show the counter position of the previous cycle.
module display_scan_scheduler #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int OVL_FRAMES   = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a_bcd,
    input  logic [15:0] b_bcd,
    input  logic        b_req,
    input  logic        lz_en,
    output logic        b_ack,
    output logic [3:0]  sel,
    output logic [3:0]  bcd_out,
    output logic        blank,
    output logic        src_b_active,
    output logic        frame_tick
);
    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam int OW = $clog2(OVL_FRAMES + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [OW-1:0] OVL_LAST  = OW'(OVL_FRAMES - 1);

    typedef enum logic {SHOW_A, SHOW_B} src_e;

    src_e          src_q, src_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [15:0]   fbuf_q, fbuf_d;
    logic [15:0]   obuf_q, obuf_d;
    logic [OW-1:0] ovl_q, ovl_d;
    logic [3:0]    sel_q, sel_d;
    logic [3:0]    bcd_q, bcd_d;
    logic          blank_q, blank_d;
    logic          b_ack_q, b_ack_d;
    logic          src_b_q, src_b_d;
    logic          tick_q, tick_d;

    logic       slot_end, boundary, in_blank, suppress;
    logic       zero3, zero2, zero1;
    logic [3:0] nib;

    always_comb begin
        src_d   = src_q;
        fbuf_d  = fbuf_q;
        obuf_d  = obuf_q;
        ovl_d   = ovl_q;
        b_ack_d = 1'b0;

        slot_end = (cnt_q == SLOT_LAST);
        boundary = slot_end && (dig_q == 2'd3);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        dig_d    = slot_end ? dig_q + 2'd1 : dig_q;
        tick_d   = boundary;

        // The overlay word goes straight into the frame buffer on acceptance,
        // so the first B frame follows the accepting boundary immediately.
        if (boundary) begin
            case (src_q)
                SHOW_A: begin
                    if (b_req) begin
                        src_d   = SHOW_B;
                        obuf_d  = b_bcd;
                        fbuf_d  = b_bcd;
                        ovl_d   = OVL_LAST;
                        b_ack_d = 1'b1;
                    end else begin
                        fbuf_d = a_bcd;
                    end
                end
                SHOW_B: begin
                    if (ovl_q != '0) begin
                        ovl_d  = ovl_q - 1'b1;
                        fbuf_d = obuf_q;
                    end else begin
                        src_d  = SHOW_A;
                        fbuf_d = a_bcd;
                    end
                end
                default: src_d = SHOW_A;
            endcase
        end
        src_b_d = (src_d == SHOW_B);

        case (dig_q)
            2'd0:    nib = fbuf_q[3:0];
            2'd1:    nib = fbuf_q[7:4];
            2'd2:    nib = fbuf_q[11:8];
            default: nib = fbuf_q[15:12];
        endcase

        zero3 = (fbuf_q[15:12] == 4'd0);
        zero2 = zero3 && (fbuf_q[11:8] == 4'd0);
        zero1 = zero2 && (fbuf_q[7:4] == 4'd0);
        case (dig_q)
            2'd1:    suppress = lz_en && zero1;
            2'd2:    suppress = lz_en && zero2;
            2'd3:    suppress = lz_en && zero3;
            default: suppress = 1'b0;
        endcase

        in_blank = (cnt_q < BLANK_END);
        bcd_d    = nib;
        blank_d  = in_blank || suppress;
        sel_d    = blank_d ? 4'b1111 : ~(4'b0001 << dig_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q   <= SHOW_A;
            cnt_q   <= '0;
            dig_q   <= 2'd0;
            fbuf_q  <= 16'd0;
            obuf_q  <= 16'd0;
            ovl_q   <= '0;
            sel_q   <= 4'b1111;
            bcd_q   <= 4'd0;
            blank_q <= 1'b1;
            b_ack_q <= 1'b0;
            src_b_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            fbuf_q  <= fbuf_d;
            obuf_q  <= obuf_d;
            ovl_q   <= ovl_d;
            sel_q   <= sel_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            b_ack_q <= b_ack_d;
            src_b_q <= src_b_d;
            tick_q  <= tick_d;
        end
    end

    assign sel          = sel_q;
    assign bcd_out      = bcd_q;
    assign blank        = blank_q;
    assign b_ack        = b_ack_q;
    assign src_b_active = src_b_q;
    assign frame_tick   = tick_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb/tb_display_scan_scheduler.sv - self-checking bench for display_scan_scheduler
// Frame-level reference model; output vector is {sel, bcd_out, blank, b_ack, src_b_active, frame_tick}.
module tb_display_scan_scheduler;
    localparam int SLOT  = 8;
    localparam int BLNK  = 2;
    localparam int OVLF  = 3;
    localparam int FRAME = 4 * SLOT;
    localparam logic [11:0] RST_VEC = 12'hF08;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a_bcd = 16'd0;
    logic [15:0] b_bcd = 16'd0;
    logic        b_req = 1'b0;
    logic        lz_en = 1'b0;
    logic        b_ack;
    logic [3:0]  sel;
    logic [3:0]  bcd_out;
    logic        blank;
    logic        src_b_active;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // reference model state
    int          m_pos;
    logic [15:0] m_buf;
    logic [15:0] m_ovl;
    logic        m_b;
    int          m_left;
    logic [11:0] e_vec;

    display_scan_scheduler #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLNK), .OVL_FRAMES(OVLF)) dut (
        .clk(clk), .reset(reset), .a_bcd(a_bcd), .b_bcd(b_bcd), .b_req(b_req), .lz_en(lz_en),
        .b_ack(b_ack), .sel(sel), .bcd_out(bcd_out), .blank(blank),
        .src_b_active(src_b_active), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] dut_vec();
        return {sel, bcd_out, blank, b_ack, src_b_active, frame_tick};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_buf = 16'd0; m_ovl = 16'd0; m_b = 1'b0; m_left = 0;
    endtask

    // Computes what the pins show after the coming edge, then advances one edge.
    task automatic step();
        int d, c;
        logic [3:0] nib, e_sel, one;
        logic on, supp, ack, tick;
        d = m_pos / SLOT;
        c = m_pos % SLOT;
        nib  = 4'((m_buf >> (4 * d)) & 16'hF);
        supp = lz_en && (d > 0) && ((m_buf >> (4 * d)) == 16'd0);
        on   = (c >= BLNK) && !supp;
        one  = 4'b0001;
        e_sel = on ? ~(one << d) : 4'hF;
        tick = (m_pos == FRAME - 1);
        ack  = 1'b0;
        if (tick) begin
            if (m_b) begin
                m_left = m_left - 1;
                if (m_left > 0) m_buf = m_ovl;
                else begin m_b = 1'b0; m_buf = a_bcd; end
            end else if (b_req) begin
                m_b = 1'b1; m_left = OVLF; m_ovl = b_bcd; m_buf = b_bcd; ack = 1'b1;
            end else begin
                m_buf = a_bcd;
            end
        end
        e_vec = {e_sel, nib, !on, ack, m_b, tick};
        m_pos = (m_pos + 1) % FRAME;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int first_tick;
        reset = 1'b1; a_bcd = 16'd0; lz_en = 1'b0; b_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            errors++; $display("FAIL reset_vals got=%h exp=%h", dut_vec(), RST_VEC);
        end
        release_reset();
        first_tick = -1;
        for (int i = 0; i < FRAME + 8; i++) begin
            step();
            if (frame_tick && first_tick < 0) first_tick = i + 1;
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL reset_seq cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
        end
        checks++;
        if (first_tick != FRAME) begin
            errors++; $display("FAIL first_tick got=%0d exp=%0d", first_tick, FRAME);
        end
    endtask

    task automatic test_basic();
        int ticks;
        a_bcd = 16'h1234;
        ticks = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            step();
            if (frame_tick) ticks++;
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
        end
        checks++;
        if (ticks != 3) begin
            errors++; $display("FAIL basic_ticks got=%0d exp=3", ticks);
        end
    endtask

    task automatic test_lz();
        logic [15:0] pats [4];
        pats[0] = 16'h0050; pats[1] = 16'h0000; pats[2] = 16'h0A07; pats[3] = 16'h00F0;
        lz_en = 1'b1;
        for (int p = 0; p < 4; p++) begin
            a_bcd = pats[p];
            for (int i = 0; i < 2 * FRAME; i++) begin
                step();
                checks++;
                if (dut_vec() !== e_vec) begin
                    errors++; $display("FAIL lz pat=%h cyc=%0d got=%h exp=%h", pats[p], i, dut_vec(), e_vec);
                end
            end
        end
        // random words biased toward zero nibbles, lz_en toggled at random
        for (int i = 0; i < 8 * FRAME; i++) begin
            if (i % 13 == 0) begin
                for (int k = 0; k < 4; k++)
                    a_bcd[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
                lz_en = 1'($urandom_range(0, 1));
            end
            step();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL lz_rand cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_overlay();
        int acks, b_frames;
        a_bcd = 16'h1234;
        repeat (11) step();
        b_req = 1'b1; b_bcd = 16'h9999;
        acks = 0; b_frames = 0;
        for (int i = 0; i < 6 * FRAME; i++) begin
            step();
            if (b_ack) begin acks++; b_req = 1'b0; b_bcd = 16'($urandom); end
            if (frame_tick && src_b_active) b_frames++;
            if (i % 20 == 7) a_bcd = 16'($urandom);
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL overlay cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
        end
        checks++;
        if (acks != 1 || b_frames != OVLF) begin
            errors++; $display("FAIL overlay_count acks=%0d bframes=%0d exp=1/%0d", acks, b_frames, OVLF);
        end
        b_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int last_ack, gap_err;
        b_req = 1'b1; b_bcd = 16'h4821;
        last_ack = -1; gap_err = 0;
        for (int i = 0; i < 14 * FRAME; i++) begin
            step();
            if (i % 9 == 0) a_bcd = 16'($urandom);
            if (b_ack) begin
                if (last_ack >= 0 && (i - last_ack) != (OVLF + 1) * FRAME) gap_err++;
                last_ack = i;
            end
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL b2b cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
        end
        checks++;
        if (gap_err != 0 || last_ack < 0) begin
            errors++; $display("FAIL b2b_gap bad_gaps=%0d last_ack=%0d exp=0 gaps", gap_err, last_ack);
        end
    endtask

    task automatic test_reset_mid();
        int found;
        b_req = 1'b1; b_bcd = 16'h7777; a_bcd = 16'h0321;
        found = 0;
        for (int i = 0; i < 10 * FRAME && found == 0; i++) begin
            step();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL pre_rst cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
            if (m_b && (m_pos % SLOT) == 5 && !b_ack) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++; $display("FAIL reset_mid_reach got=0 exp=1");
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== RST_VEC) begin
            errors++; $display("FAIL reset_mid got=%h exp=%h", dut_vec(), RST_VEC);
        end
        b_req = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            checks++;
            if (dut_vec() !== e_vec) begin
                errors++; $display("FAIL post_rst cyc=%0d got=%h exp=%h", i, dut_vec(), e_vec);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_lz();
        test_overlay();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
